// File: rtl/fll_cfg_pkg.sv
// Shared constants for the FLL configuration responder: register map, field positions,
// reset values and the bus FSM state type.
package fll_cfg_pkg;

  localparam logic [1:0] RegStatus = 2'd0;
  localparam logic [1:0] RegCfg1   = 2'd1;
  localparam logic [1:0] RegCfg2   = 2'd2;
  localparam logic [1:0] RegInteg  = 2'd3;

  localparam int unsigned Cfg1MultLsb   = 0;
  localparam int unsigned Cfg1DcoLsb    = 16;
  localparam int unsigned Cfg1DivLsb    = 26;
  localparam int unsigned Cfg1ModeBit   = 31;
  localparam int unsigned Cfg2GainLsb   = 0;
  localparam int unsigned Cfg2TolLsb    = 4;
  localparam int unsigned Cfg2LockLsb   = 16;
  localparam int unsigned StatusLockBit = 31;
  localparam int unsigned StatusIrqBit  = 30;

  localparam logic [31:0] Cfg1Mask  = 32'hBFFF_FFFF;
  localparam logic [31:0] Cfg2Mask  = 32'h003F_FFFF;
  localparam logic [31:0] IntegMask = 32'h03FF_0000;

  localparam logic [31:0] Cfg1Rst  = 32'h8400_05F5;
  localparam logic [31:0] Cfg2Rst  = 32'h0010_0048;
  localparam logic [31:0] IntegRst = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAck,
    StRel
  } fll_state_e;

endpackage

// File: rtl/fll_cfg_responder_if.sv
// Native FLL configuration bus: req/ack handshake, 2-bit register index, 32-bit data,
// active-low write strobe.
interface fll_cfg_responder_if;
  logic        req;
  logic        ack;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic        wrn;
  logic [31:0] rdata;

  modport master (output req, addr, wdata, wrn, input ack, rdata);
  modport slave  (input req, addr, wdata, wrn, output ack, rdata);
endinterface

// File: rtl/fll_lock_detect.sv
// Lock detector: tolerance compare of measured count against the multiplication factor,
// consecutive-good counter, lock flag; unlock pulse when FLL_CFG_UNLOCK_IRQ_EN is defined.
module fll_lock_detect #(
  parameter int unsigned MEAS_W     = 16,
  parameter int unsigned LOCK_CNT_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              meas_valid_i,
  input  logic [MEAS_W-1:0] meas_i,
  input  logic [MEAS_W-1:0] mult_i,
  input  logic [11:0]       tol_i,
  input  logic [5:0]        lock_cycles_i,
  input  logic              mode_i,
  input  logic              clear_i,
`ifdef FLL_CFG_UNLOCK_IRQ_EN
  output logic              unlock_o,
`endif
  output logic [MEAS_W-1:0] meas_q_o,
  output logic              lock_o
);

  logic [MEAS_W-1:0]     r_meas;
  logic [LOCK_CNT_W-1:0] r_cnt, w_cnt_d, w_cnt_inc;
  logic                  r_lock, w_lock_d;
  logic signed [MEAS_W:0] w_diff;
  logic [MEAS_W:0]       w_abs;
  logic                  w_in_tol;

  // One extra bit keeps the difference exact, so large gaps never wrap into tolerance.
  assign w_diff   = $signed({1'b0, meas_i}) - $signed({1'b0, mult_i});
  assign w_abs    = w_diff[MEAS_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
  assign w_in_tol = 32'(w_abs) <= 32'(tol_i);
  assign w_cnt_inc = (32'(r_cnt) < 32'(lock_cycles_i)) ? r_cnt + LOCK_CNT_W'(1) : r_cnt;

`ifdef FLL_CFG_UNLOCK_IRQ_EN
  logic r_unlock, w_unlock_d;
`endif

  always_comb begin
    w_cnt_d  = r_cnt;
    w_lock_d = r_lock;
`ifdef FLL_CFG_UNLOCK_IRQ_EN
    w_unlock_d = 1'b0;
`endif
    if (clear_i || !mode_i) begin
      w_cnt_d  = '0;
      w_lock_d = 1'b0;
    end else if (meas_valid_i) begin
      if (w_in_tol) begin
        w_cnt_d  = w_cnt_inc;
        w_lock_d = 32'(w_cnt_inc) >= 32'(lock_cycles_i);
      end else begin
        w_cnt_d  = '0;
        w_lock_d = 1'b0;
`ifdef FLL_CFG_UNLOCK_IRQ_EN
        w_unlock_d = r_lock;
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_meas <= '0;
      r_cnt  <= '0;
      r_lock <= 1'b0;
`ifdef FLL_CFG_UNLOCK_IRQ_EN
      r_unlock <= 1'b0;
`endif
    end else begin
      if (meas_valid_i) r_meas <= meas_i;
      r_cnt  <= w_cnt_d;
      r_lock <= w_lock_d;
`ifdef FLL_CFG_UNLOCK_IRQ_EN
      r_unlock <= w_unlock_d;
`endif
    end
  end

  assign meas_q_o = r_meas;
  assign lock_o   = r_lock;
`ifdef FLL_CFG_UNLOCK_IRQ_EN
  assign unlock_o = r_unlock;
`endif

endmodule

// File: rtl/fll_cfg_responder.sv
// FLL configuration bus responder: handshake FSM, register file and static oscillator
// controls. Optional unlock interrupt and sticky STATUS[30] under FLL_CFG_UNLOCK_IRQ_EN.
module fll_cfg_responder
  import fll_cfg_pkg::*;
#(
  parameter int unsigned ACK_LATENCY = 1,
  parameter int unsigned MEAS_W      = 16,
  parameter int unsigned LOCK_CNT_W  = 6
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  fll_cfg_responder_if.slave  bus,
  output logic                lock_o,
`ifdef FLL_CFG_UNLOCK_IRQ_EN
  output logic                unlock_irq_o,
`endif
  input  logic                meas_valid_i,
  input  logic [MEAS_W-1:0]   meas_i,
  output logic [MEAS_W-1:0]   mult_o,
  output logic [9:0]          dco_o,
  output logic [3:0]          div_o,
  output logic                mode_o,
  output logic [3:0]          gain_o
);

  fll_state_e  r_state, w_state_d;
  logic [3:0]  r_wait_cnt, w_wait_cnt_d;
  logic [1:0]  r_addr;
  logic [31:0] r_wdata;
  logic        r_wrn;
  logic [31:0] r_cfg1, r_cfg2, r_integ;
  logic [31:0] w_status, w_rdata;
  logic        w_ack, w_wr, w_cfg_wr, w_lock;
  logic [MEAS_W-1:0] w_meas_q;

  always_comb begin
    w_state_d    = r_state;
    w_wait_cnt_d = r_wait_cnt;
    unique case (r_state)
      StIdle: begin
        if (bus.req) begin
          w_wait_cnt_d = '0;
          w_state_d    = (ACK_LATENCY > 1) ? StWait : StAck;
        end
      end
      StWait: begin
        // WAIT spans ACK_LATENCY-1 cycles so ack lands ACK_LATENCY cycles after acceptance.
        if (32'(r_wait_cnt) + 32'd2 >= ACK_LATENCY) w_state_d = StAck;
        else w_wait_cnt_d = r_wait_cnt + 4'd1;
      end
      StAck:   w_state_d = StRel;
      StRel:   if (!bus.req) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= StIdle;
      r_wait_cnt <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wrn      <= 1'b1;
    end else begin
      r_state    <= w_state_d;
      r_wait_cnt <= w_wait_cnt_d;
      if (r_state == StIdle && bus.req) begin
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
        r_wrn   <= bus.wrn;
      end
    end
  end

  assign w_ack    = (r_state == StAck);
  assign w_wr     = w_ack && !r_wrn;
  assign w_cfg_wr = w_wr && (r_addr == RegCfg1 || r_addr == RegCfg2);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cfg1  <= Cfg1Rst;
      r_cfg2  <= Cfg2Rst;
      r_integ <= IntegRst;
    end else if (w_wr) begin
      case (r_addr)
        RegCfg1:  r_cfg1  <= r_wdata & Cfg1Mask;
        RegCfg2:  r_cfg2  <= r_wdata & Cfg2Mask;
        RegInteg: r_integ <= r_wdata & IntegMask;
        default:  ;
      endcase
    end
  end

  fll_lock_detect #(
    .MEAS_W     (MEAS_W),
    .LOCK_CNT_W (LOCK_CNT_W)
  ) u_lock_detect (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .meas_valid_i  (meas_valid_i),
    .meas_i        (meas_i),
    .mult_i        (mult_o),
    .tol_i         (r_cfg2[Cfg2TolLsb +: 12]),
    .lock_cycles_i (r_cfg2[Cfg2LockLsb +: 6]),
    .mode_i        (mode_o),
    .clear_i       (w_cfg_wr),
`ifdef FLL_CFG_UNLOCK_IRQ_EN
    .unlock_o      (unlock_irq_o),
`endif
    .meas_q_o      (w_meas_q),
    .lock_o        (w_lock)
  );

`ifdef FLL_CFG_UNLOCK_IRQ_EN
  logic r_irq_sticky;

  // Set wins over a STATUS read clearing in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_irq_sticky <= 1'b0;
    else if (unlock_irq_o) r_irq_sticky <= 1'b1;
    else if (w_ack && r_wrn && r_addr == RegStatus) r_irq_sticky <= 1'b0;
  end
`endif

  always_comb begin
    w_status                = '0;
    w_status[StatusLockBit] = w_lock;
    w_status[15:0]          = 16'(w_meas_q);
`ifdef FLL_CFG_UNLOCK_IRQ_EN
    w_status[StatusIrqBit]  = r_irq_sticky;
`endif
  end

  always_comb begin
    w_rdata = '0;
    if (w_ack) begin
      case (r_addr)
        RegStatus: w_rdata = w_status;
        RegCfg1:   w_rdata = r_cfg1;
        RegCfg2:   w_rdata = r_cfg2;
        default:   w_rdata = r_integ;
      endcase
    end
  end

  assign bus.ack   = w_ack;
  assign bus.rdata = w_rdata;
  assign lock_o    = w_lock;
  assign mult_o    = r_cfg1[Cfg1MultLsb +: MEAS_W];
  assign dco_o     = r_cfg1[Cfg1DcoLsb +: 10];
  assign div_o     = r_cfg1[Cfg1DivLsb +: 4];
  assign mode_o    = r_cfg1[Cfg1ModeBit];
  assign gain_o    = r_cfg2[Cfg2GainLsb +: 4];

endmodule

// File: tb/tb_fll_cfg_responder.sv
// Directed bench for fll_cfg_responder: instance A uses ACK_LATENCY=1, instance B uses
// ACK_LATENCY=4. Unlock interrupt checks compile in when FLL_CFG_UNLOCK_IRQ_EN is defined.
module tb_fll_cfg_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, rst_b_n;
  logic        lock_a, lock_b, mv_a, mv_b, mode_a, mode_b;
  logic [15:0] meas_a, meas_b, mult_a, mult_b;
  logic [9:0]  dco_a, dco_b;
  logic [3:0]  div_a, div_b, gain_a, gain_b;
`ifdef FLL_CFG_UNLOCK_IRQ_EN
  logic        irq_a, irq_b;
  localparam logic [31:0] IrqBit = 32'h4000_0000;
`else
  localparam logic [31:0] IrqBit = 32'h0000_0000;
`endif

  fll_cfg_responder_if ifa ();
  fll_cfg_responder_if ifb ();

  fll_cfg_responder #(.ACK_LATENCY(1), .MEAS_W(16), .LOCK_CNT_W(6)) u_dut_a (
    .clk_i        (clk),
    .rst_ni       (rst_a_n),
    .bus          (ifa),
    .lock_o       (lock_a),
`ifdef FLL_CFG_UNLOCK_IRQ_EN
    .unlock_irq_o (irq_a),
`endif
    .meas_valid_i (mv_a),
    .meas_i       (meas_a),
    .mult_o       (mult_a),
    .dco_o        (dco_a),
    .div_o        (div_a),
    .mode_o       (mode_a),
    .gain_o       (gain_a)
  );

  fll_cfg_responder #(.ACK_LATENCY(4), .MEAS_W(16), .LOCK_CNT_W(6)) u_dut_b (
    .clk_i        (clk),
    .rst_ni       (rst_b_n),
    .bus          (ifb),
    .lock_o       (lock_b),
`ifdef FLL_CFG_UNLOCK_IRQ_EN
    .unlock_irq_o (irq_b),
`endif
    .meas_valid_i (mv_b),
    .meas_i       (meas_b),
    .mult_o       (mult_b),
    .dco_o        (dco_b),
    .div_o        (div_b),
    .mode_o       (mode_b),
    .gain_o       (gain_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  int irq_cnt  = 0;

`ifdef FLL_CFG_UNLOCK_IRQ_EN
  always @(negedge clk) if (irq_a === 1'b1) irq_cnt++;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one bus transfer; req drops once ack was seen and at least `hold` cycles passed.
  task automatic xfer(input bit sel_b, input logic wr, input logic [1:0] a,
                      input logic [31:0] d, input int hold,
                      output logic [31:0] rd, output int lat, output int nack);
    logic        ack_s;
    logic [31:0] rd_s;
    lat = -1; nack = 0; rd = '0;
    if (sel_b) begin ifb.req = 1'b1; ifb.wrn = ~wr; ifb.addr = a; ifb.wdata = d; end
    else       begin ifa.req = 1'b1; ifa.wrn = ~wr; ifa.addr = a; ifa.wdata = d; end
    for (int i = 1; i <= hold + 16; i++) begin
      @(negedge clk);
      ack_s = sel_b ? ifb.ack : ifa.ack;
      rd_s  = sel_b ? ifb.rdata : ifa.rdata;
      if (ack_s === 1'b1) begin
        nack++;
        if (lat < 0) begin lat = i; rd = rd_s; end
      end
      if (lat >= 0 && i >= hold) begin
        if (sel_b) ifb.req = 1'b0; else ifa.req = 1'b0;
      end
    end
    ifa.req = sel_b ? ifa.req : 1'b0;
    ifb.req = sel_b ? 1'b0 : ifb.req;
  endtask

  task automatic rd_chk(input bit sel_b, input logic [1:0] a, input logic [31:0] exp,
                        input string tag);
    logic [31:0] r; int l, n;
    xfer(sel_b, 1'b0, a, 32'h0, 0, r, l, n);
    check(tag, r, exp);
  endtask

  task automatic wr_reg(input bit sel_b, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r; int l, n;
    xfer(sel_b, 1'b1, a, d, 0, r, l, n);
  endtask

  task automatic send_meas(input logic [15:0] v);
    mv_a = 1'b1; meas_a = v;
    @(negedge clk);
    mv_a = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    int          l, n, irq_base;
    logic        ack_seen;

    rst_a_n = 1'b0; rst_b_n = 1'b0;
    mv_a = 1'b0; meas_a = '0; mv_b = 1'b0; meas_b = '0;
    ifa.req = 1'b0; ifa.wrn = 1'b1; ifa.addr = '0; ifa.wdata = '0;
    ifb.req = 1'b0; ifb.wrn = 1'b1; ifb.addr = '0; ifb.wdata = '0;
    repeat (3) @(negedge clk);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_ack", 32'(ifa.ack), 32'h0);
    check("rst_rdata", ifa.rdata, 32'h0);
    check("rst_lock", 32'(lock_a), 32'h0);
    check("rst_cfg1_outs", {mode_a, 1'b0, div_a, dco_a, mult_a}, 32'h8400_05F5);
    check("rst_gain", 32'(gain_a), 32'h8);

    // 1: reads after reset, latency 1
    xfer(1'b0, 1'b0, 2'd1, 32'h0, 0, r, l, n);
    check("rd_cfg1_val", r, 32'h8400_05F5);
    check("rd_cfg1_lat", 32'(l), 32'd1);
    check("rd_cfg1_nack", 32'(n), 32'd1);
    check("rdata_idle_zero", ifa.rdata, 32'h0);
    rd_chk(1'b0, 2'd3, 32'h0, "rd_integ_rst");
    rd_chk(1'b0, 2'd2, 32'h0010_0048, "rd_cfg2_rst");
    rd_chk(1'b0, 2'd0, 32'h0, "rd_status_rst");

    // 2: write with req held 5 cycles
    xfer(1'b0, 1'b1, 2'd1, 32'h8000_0100, 5, r, l, n);
    check("wr_hold_nack", 32'(n), 32'd1);
    check("wr_mult", 32'(mult_a), 32'h100);
    check("wr_div_dco", {div_a, dco_a}, 32'h0);
    rd_chk(1'b0, 2'd1, 32'h8000_0100, "rd_cfg1_back");
    wr_reg(1'b0, 2'd3, 32'hFFFF_FFFF);
    rd_chk(1'b0, 2'd3, 32'h03FF_0000, "rd_integ_mask");
    xfer(1'b0, 1'b1, 2'd0, 32'hFFFF_FFFF, 0, r, l, n);
    check("wr_status_nack", 32'(n), 32'd1);
    rd_chk(1'b0, 2'd0, 32'h0, "rd_status_after_wr");

    // 3: lock on 4 good samples, lose it on a bad one
    wr_reg(1'b0, 2'd2, 32'h0004_0043);
    check("gain_wr", 32'(gain_a), 32'h3);
    repeat (3) send_meas(16'h0102);
    check("lock_after3", 32'(lock_a), 32'h0);
    send_meas(16'h0102);
    check("lock_after4", 32'(lock_a), 32'h1);
    rd_chk(1'b0, 2'd0, 32'h8000_0102, "status_locked");
    send_meas(16'h00FC);
    check("lock_tol_edge", 32'(lock_a), 32'h1);
    irq_base = irq_cnt;
    send_meas(16'h0110);
    check("lock_lost", 32'(lock_a), 32'h0);
`ifdef FLL_CFG_UNLOCK_IRQ_EN
    // 6: unlock pulse and sticky STATUS[30]
    check("irq_pulse", 32'(irq_a), 32'h1);
    @(negedge clk);
    check("irq_one_cycle", 32'(irq_a), 32'h0);
`endif
    rd_chk(1'b0, 2'd0, IrqBit | 32'h0000_0110, "status_irq_set");
    rd_chk(1'b0, 2'd0, 32'h0000_0110, "status_irq_clr");
`ifdef FLL_CFG_UNLOCK_IRQ_EN
    check("irq_count_bad", 32'(irq_cnt - irq_base), 32'd1);
`endif

    // 4: CFG2 write with a coincident sample clears lock; relock needs 4 samples
    irq_base = irq_cnt;
    repeat (4) send_meas(16'h0102);
    check("relock_pre", 32'(lock_a), 32'h1);
    ifa.req = 1'b1; ifa.wrn = 1'b0; ifa.addr = 2'd2; ifa.wdata = 32'h0004_0043;
    @(negedge clk);
    check("coinc_ack", 32'(ifa.ack), 32'h1);
    mv_a = 1'b1; meas_a = 16'h00FE;
    @(negedge clk);
    mv_a = 1'b0; ifa.req = 1'b0;
    check("coinc_lock_clr", 32'(lock_a), 32'h0);
    repeat (2) @(negedge clk);
    rd_chk(1'b0, 2'd0, 32'h0000_00FE, "coinc_meas_stored");
    repeat (3) send_meas(16'h0102);
    check("coinc_relock3", 32'(lock_a), 32'h0);
    send_meas(16'h0102);
    check("coinc_relock4", 32'(lock_a), 32'h1);
`ifdef FLL_CFG_UNLOCK_IRQ_EN
    check("irq_none_cfgwr", 32'(irq_cnt - irq_base), 32'd0);
`endif

    // Open loop forces lock low
    wr_reg(1'b0, 2'd1, 32'h0000_0100);
    repeat (5) send_meas(16'h0100);
    check("open_loop_lock", 32'(lock_a), 32'h0);

    // lock_cycles=0 locks immediately; far sample must not wrap into tolerance
    wr_reg(1'b0, 2'd1, 32'h8000_0002);
    wr_reg(1'b0, 2'd2, 32'h0000_0043);
    send_meas(16'h0005);
    check("lc0_lock", 32'(lock_a), 32'h1);
    send_meas(16'hFFFF);
    check("nowrap_unlock", 32'(lock_a), 32'h0);

    // 5: instance B, latency 4, then reset during WAIT on a write
    xfer(1'b1, 1'b0, 2'd1, 32'h0, 0, r, l, n);
    check("b_rd_val", r, 32'h8400_05F5);
    check("b_rd_lat", 32'(l), 32'd4);
    ack_seen = 1'b0;
    ifb.req = 1'b1; ifb.wrn = 1'b0; ifb.addr = 2'd1; ifb.wdata = 32'h1234_5678;
    repeat (2) begin @(negedge clk); ack_seen |= ifb.ack; end
    rst_b_n = 1'b0; ifb.req = 1'b0;
    repeat (3) begin @(negedge clk); ack_seen |= ifb.ack; end
    rst_b_n = 1'b1;
    repeat (4) begin @(negedge clk); ack_seen |= ifb.ack; end
    check("b_rst_no_ack", 32'(ack_seen), 32'h0);
    check("b_rst_mult", 32'(mult_b), 32'h05F5);
    rd_chk(1'b1, 2'd1, 32'h8400_05F5, "b_cfg1_kept");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fll_cfg_responder.md
Name: fll_cfg_responder

Overview:
- Responder end of the native FLL configuration bus (req/ack, 2-bit addr, 32-bit data, active-low write strobe, lock). This is the bus that the APB-to-FLL bridge drives.
- Holds the FLL register file and drives static oscillator-control outputs.
- Generates lock_o from measured-frequency samples.
- Synthesizable stand-in for hard FLL macros, used on FPGA and in ASIC-less builds; sits directly behind the bridge in the clock-generation block.

Parameters:
- ACK_LATENCY, 1, cycles from accepted req to ack_o (1..15)
- MEAS_W, 16, width of measured-count input and multiplication factor
- LOCK_CNT_W, 6, width of consecutive-in-tolerance counter

Ports:
- clk_i  in  1  configuration clock
- rst_ni  in  1  synchronous active-low reset
- req_i  in  1  request; initiator holds it high until ack_o
- ack_o  out  1  one-cycle acknowledge
- addr_i  in  2  register index
- wdata_i  in  32  write data
- wrn_i  in  1  0 = write, 1 = read
- rdata_o  out  32  read data, valid only while ack_o is high, else 0
- lock_o  out  1  FLL locked
- meas_valid_i  in  1  new measurement sample strobe
- meas_i  in  MEAS_W  measured ref-period cycle count
- mult_o  out  MEAS_W  target multiplication factor (CFG1[15:0])
- dco_o  out  10  DCO code (CFG1[25:16])
- div_o  out  4  output divider (CFG1[29:26])
- mode_o  out  1  1 = closed loop (CFG1[31])
- gain_o  out  4  loop gain (CFG2[3:0])

Behaviour:
- Registers:
  - 0 STATUS (RO): [31] lock_o, [15:0] last meas_i
  - 1 CFG1 (RW): reset 0x8400_05F5
  - 2 CFG2 (RW): [3:0] gain, [15:4] tolerance, [21:16] lock_cycles; reset 0x0010_0048
  - 3 INTEG (RW): [25:16] integrator, rest 0; reset 0
- Unused bits read 0. Writes to STATUS are acknowledged and ignored.
- FSM:
  - IDLE: req_i=1 → latch addr/wdata/wrn, go to WAIT.
  - WAIT: count ACK_LATENCY-1 cycles, then go to ACK. ACK_LATENCY=1 goes straight to ACK.
  - ACK: ack_o=1 for one cycle. Write commits this cycle; rdata_o is driven from the latched addr. Go to REL.
  - REL: wait for req_i=0, then go to IDLE.
- A request is accepted only in IDLE. A req_i still high in REL is not a new request.
- Reset mid-transaction: FSM returns to IDLE, no ack is issued, and no partial write is made.
- Reset state: all registers at their reset values, ack_o=0, rdata_o=0, lock_o=0, lock counter 0, STATUS meas field 0.
- Lock logic:
  - On each meas_valid_i: store meas_i.
  - In tolerance: |meas_i − mult_o| ≤ tolerance, computed at MEAS_W+1 bits signed, no wrap.
  - In tolerance and counter < lock_cycles: counter++.
  - Counter reaching lock_cycles: lock_o=1 on the next cycle.
  - Out of tolerance: counter=0, lock_o=0 on the next cycle.
  - lock_cycles=0: lock_o asserts on the first in-tolerance sample.
  - mode_o=0 (open loop): lock_o forced 0, counter held 0.
- A committed write to CFG1 or CFG2 clears the counter and lock_o in the same cycle as the commit. A coincident meas_valid_i that cycle is discarded for lock purposes; meas_i is still stored.

Optional Feature:
- Macro FLL_CFG_UNLOCK_IRQ_EN.
- Defined:
  - Adds port unlock_irq_o (out, 1, reset 0).
  - unlock_irq_o pulses one cycle when lock_o falls due to an out-of-tolerance sample. No pulse for CFG writes or mode change.
  - Sets sticky STATUS[30]; a STATUS read clears it at ack. A set and a clear in the same cycle leave it set.
- Undefined: no port; STATUS[30] reads 0.

Decomposition:
- Package fll_cfg_pkg:
  - register index constants
  - field bit-position localparams
  - CFG1/CFG2/INTEG reset values
  - FSM state enum
- Sub-module fll_lock_detect holds the tolerance compare, counter and lock_o (and unlock pulse). The top level holds the FSM and register file.

Test Plan:
1. Reset, then read addr 1 → ack_o one cycle, ACK_LATENCY cycles after req; rdata_o=0x8400_05F5. Read addr 3 → 0.
2. Write CFG1=0x8000_0100 while req is held 5 cycles → exactly one ack; mult_o=0x0100; a subsequent read returns 0x8000_0100.
3. mult=0x100, tol=4, lock_cycles=4; feed 4 samples of 0x102 → lock_o=1 the cycle after the 4th; one sample of 0x110 → lock_o=0.
4. Locked, then write CFG2 with a coincident meas_valid_i → lock_o=0, counter 0; 4 further good samples are required to relock.
5. Assert rst_ni=0 during WAIT with ACK_LATENCY=4 on a write → no ack; register keeps its reset value.
6. With FLL_CFG_UNLOCK_IRQ_EN defined: lose lock via a bad sample → one unlock_irq_o pulse; STATUS read returns bit30=1, next read returns bit30=0.
